// File: rtl/vend_ctrl_param.sv
// Parametrised vending-machine controller: coin credit accumulator, price-list
// vending with change return, cancel/refund, inactivity timeout, overflow reject.
module vend_ctrl_param #(
  parameter int NUM_PROD = 4,
  parameter int CREDIT_W = 6,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_LIST = {6'd20, 6'd15, 6'd10, 6'd5},
  parameter int TIMEOUT = 255,
  localparam int SEL_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin5,
  input  logic                coin10,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_prod,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic                sel_denied,
  output logic                busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W:0]   NP_L    = (SEL_W + 1)'(NUM_PROD);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, RETURN} state_t;

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_amt_q;
  logic [SEL_W-1:0]    vend_prod_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                vend_valid_q;
  logic                change_valid_q;
  logic                coin_reject_q;
  logic                sel_denied_q;
  logic                busy_q;

  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;
  logic                coin_any;
  logic                fits;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;

  // Out-of-range indices resolve to price 0; they are rejected separately.
  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (idx == SEL_W'(i)) p = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
    end
    return p;
  endfunction

  always_comb begin
    coin_val = '0;
    if (coin5)  coin_val = coin_val + (CREDIT_W + 1)'(5);
    if (coin10) coin_val = coin_val + (CREDIT_W + 1)'(10);
  end

  // Overflow is detected in the extra carry bit; a coin is never partially accepted.
  assign coin_any  = coin5 | coin10;
  assign sum       = {1'b0, credit_q} + coin_val;
  assign fits      = ~sum[CREDIT_W];
  assign sel_price = price_of(sel);
  assign sel_ok    = sel_valid && ({1'b0, sel} < NP_L) && (credit_q >= sel_price);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      change_amt_q   <= '0;
      vend_prod_q    <= '0;
      cnt_q          <= '0;
      vend_valid_q   <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_denied_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      vend_valid_q   <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_denied_q   <= 1'b0;
      busy_q         <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sel_denied_q <= sel_valid;
          if (coin_any) begin
            if (fits) begin
              credit_q <= sum[CREDIT_W-1:0];
              cnt_q    <= '0;
              state_q  <= COLLECT;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (cancel) begin
            coin_reject_q  <= coin_any;
            change_amt_q   <= credit_q;
            change_valid_q <= 1'b1;
            busy_q         <= 1'b1;
            cnt_q          <= '0;
            state_q        <= RETURN;
          end else if (sel_ok) begin
            coin_reject_q <= coin_any;
            vend_prod_q   <= sel;
            change_amt_q  <= credit_q - sel_price;
            vend_valid_q  <= 1'b1;
            busy_q        <= 1'b1;
            cnt_q         <= '0;
            state_q       <= VEND;
          end else begin
            sel_denied_q  <= sel_valid;
            coin_reject_q <= coin_any && !fits;
            if (coin_any && fits) credit_q <= sum[CREDIT_W-1:0];
            if (sel_valid || (coin_any && fits)) begin
              cnt_q <= '0;
            end else if (cnt_q == TO_LAST) begin
              change_amt_q   <= credit_q;
              change_valid_q <= 1'b1;
              busy_q         <= 1'b1;
              cnt_q          <= '0;
              state_q        <= RETURN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        VEND: begin
          coin_reject_q <= coin_any;
          sel_denied_q  <= sel_valid;
          credit_q      <= '0;
          if (change_amt_q != '0) begin
            change_valid_q <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= RETURN;
          end else begin
            state_q <= IDLE;
          end
        end
        RETURN: begin
          coin_reject_q <= coin_any;
          sel_denied_q  <= sel_valid;
          credit_q      <= '0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign credit       = credit_q;
  assign vend_valid   = vend_valid_q;
  assign vend_prod    = vend_prod_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign coin_reject  = coin_reject_q;
  assign sel_denied   = sel_denied_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: two parameterisations driven by shared inputs,
// each checked every cycle against a session-level model of the machine.
module tb_vend_ctrl_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin5 = 1'b0, coin10 = 1'b0, sel_valid = 1'b0, cancel = 1'b0;
  logic [1:0] sel = '0;

  logic [5:0] a_credit, a_change_amt;
  logic [1:0] a_vend_prod;
  logic       a_vend_valid, a_change_valid, a_coin_reject, a_sel_denied, a_busy;
  logic [7:0] b_credit, b_change_amt;
  logic [1:0] b_vend_prod;
  logic       b_vend_valid, b_change_valid, b_coin_reject, b_sel_denied, b_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vend_ctrl_param #(.NUM_PROD(4), .CREDIT_W(6),
    .PRICE_LIST({6'd20, 6'd15, 6'd10, 6'd5}), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .coin5(coin5), .coin10(coin10),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .credit(a_credit), .vend_valid(a_vend_valid), .vend_prod(a_vend_prod),
    .change_valid(a_change_valid), .change_amt(a_change_amt),
    .coin_reject(a_coin_reject), .sel_denied(a_sel_denied), .busy(a_busy));

  vend_ctrl_param #(.NUM_PROD(3), .CREDIT_W(8),
    .PRICE_LIST({8'd40, 8'd25, 8'd12}), .TIMEOUT(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .coin5(coin5), .coin10(coin10),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .credit(b_credit), .vend_valid(b_vend_valid), .vend_prod(b_vend_prod),
    .change_valid(b_change_valid), .change_amt(b_change_amt),
    .coin_reject(b_coin_reject), .sel_denied(b_sel_denied), .busy(b_busy));

  // Model: a session is "open" while credit>0; once a purchase or refund is
  // decided, the output cycles it produces are played out (vend, then change).
  int np[2]      = '{4, 3};
  int maxc[2]    = '{63, 255};
  int tmo[2]     = '{8, 20};
  int price[2][4] = '{'{5, 10, 15, 20}, '{12, 25, 40, 0}};

  int m_credit[2], m_idle[2], m_prod[2], m_amt[2], m_pend[2];
  bit m_vend[2], m_chg[2], m_rej[2], m_den[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_credit[i] = 0; m_idle[i] = 0; m_prod[i] = 0; m_amt[i] = 0; m_pend[i] = 0;
      m_vend[i] = 0; m_chg[i] = 0; m_rej[i] = 0; m_den[i] = 0;
    end
  endtask

  task automatic model_edge(input int i);
    int v;
    bit acc;
    v = 5 * int'(coin5) + 10 * int'(coin10);
    m_rej[i] = 0;
    m_den[i] = 0;
    if (m_vend[i] || m_chg[i]) begin
      m_rej[i] = (v > 0);
      m_den[i] = sel_valid;
      m_credit[i] = 0;
      m_chg[i] = m_vend[i] && (m_pend[i] > 0);
      m_vend[i] = 0;
      m_pend[i] = 0;
    end else if (m_credit[i] == 0) begin
      m_den[i] = sel_valid;
      if (v > 0) begin
        if (v <= maxc[i]) begin m_credit[i] = v; m_idle[i] = 0; end
        else m_rej[i] = 1;
      end
    end else if (cancel) begin
      m_rej[i] = (v > 0);
      m_amt[i] = m_credit[i];
      m_chg[i] = 1;
      m_idle[i] = 0;
    end else if (sel_valid && int'(sel) < np[i] && m_credit[i] >= price[i][sel]) begin
      m_rej[i] = (v > 0);
      m_prod[i] = int'(sel);
      m_amt[i] = m_credit[i] - price[i][sel];
      m_pend[i] = m_amt[i];
      m_vend[i] = 1;
      m_idle[i] = 0;
    end else begin
      m_den[i] = sel_valid;
      acc = 0;
      if (v > 0) begin
        if (m_credit[i] + v <= maxc[i]) begin m_credit[i] += v; acc = 1; end
        else m_rej[i] = 1;
      end
      if (sel_valid || acc) m_idle[i] = 0;
      else begin
        m_idle[i]++;
        if (m_idle[i] >= tmo[i]) begin
          m_amt[i] = m_credit[i];
          m_chg[i] = 1;
          m_idle[i] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string tag, input int i,
      input logic [31:0] cr, input logic [31:0] vv, input logic [31:0] vp,
      input logic [31:0] cv, input logic [31:0] ca, input logic [31:0] rj,
      input logic [31:0] dn, input logic [31:0] bz);
    chk({tag, ".credit"}, cr, m_credit[i]);
    chk({tag, ".vend_valid"}, vv, 32'(m_vend[i]));
    chk({tag, ".vend_prod"}, vp, m_prod[i]);
    chk({tag, ".change_valid"}, cv, 32'(m_chg[i]));
    chk({tag, ".change_amt"}, ca, m_amt[i]);
    chk({tag, ".coin_reject"}, rj, 32'(m_rej[i]));
    chk({tag, ".sel_denied"}, dn, 32'(m_den[i]));
    chk({tag, ".busy"}, bz, 32'(m_vend[i] | m_chg[i]));
  endtask

  task automatic check_all(input string tag);
    check_inst({tag, ".A"}, 0, 32'(a_credit), 32'(a_vend_valid), 32'(a_vend_prod),
      32'(a_change_valid), 32'(a_change_amt), 32'(a_coin_reject), 32'(a_sel_denied), 32'(a_busy));
    check_inst({tag, ".B"}, 1, 32'(b_credit), 32'(b_vend_valid), 32'(b_vend_prod),
      32'(b_change_valid), 32'(b_change_amt), 32'(b_coin_reject), 32'(b_sel_denied), 32'(b_busy));
  endtask

  // Called at posedge+1; applies inputs for the next edge, then checks #1 after it.
  task automatic step(input string tag, input bit c5, input bit c10,
      input bit sv, input logic [1:0] s, input bit cn);
    coin5 = c5; coin10 = c10; sel_valid = sv; sel = s; cancel = cn;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 0, 0, 0, 2'd0, 0);
  endtask

  task automatic do_reset();
    coin5 = 0; coin10 = 0; sel_valid = 0; sel = '0; cancel = 0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Exact price: coin5 then product 0.
    step("c5", 1, 0, 0, 2'd0, 0);
    step("sel0", 0, 0, 1, 2'd0, 0);
    chk("exact.vend", 32'(a_vend_valid), 1);
    chk("exact.prod", 32'(a_vend_prod), 0);
    step("post_exact", 0, 0, 0, 2'd0, 0);
    chk("exact.nochg", 32'(a_change_valid), 0);
    chk("exact.credit0", 32'(a_credit), 0);
    idle("gap", 2);

    // Purchase with change: 20 credit for product 2 at 15.
    step("c10a", 0, 1, 0, 2'd0, 0);
    step("c10b", 0, 1, 0, 2'd0, 0);
    step("sel2", 0, 0, 1, 2'd2, 0);
    chk("chg.vend_prod", 32'(a_vend_prod), 2);
    step("chg_cycle", 0, 0, 0, 2'd0, 0);
    chk("chg.valid", 32'(a_change_valid), 1);
    chk("chg.amt", 32'(a_change_amt), 5);
    idle("gap", 2);

    // Denied selection then cancel refund.
    step("c5", 1, 0, 0, 2'd0, 0);
    step("sel3_low", 0, 0, 1, 2'd3, 0);
    chk("deny.pulse", 32'(a_sel_denied), 1);
    chk("deny.credit", 32'(a_credit), 5);
    step("cancel", 0, 0, 0, 2'd0, 1);
    chk("cancel.amt", 32'(a_change_amt), 5);
    step("post_cancel", 0, 0, 0, 2'd0, 0);
    chk("cancel.idle", 32'(a_busy), 0);

    // Dual coins to 60, then overflow rejection.
    for (int k = 0; k < 4; k++) step("c15", 1, 1, 0, 2'd0, 0);
    chk("ovf.credit60", 32'(a_credit), 60);
    step("c5_ovf", 1, 0, 0, 2'd0, 0);
    chk("ovf.reject", 32'(a_coin_reject), 1);
    chk("ovf.hold", 32'(a_credit), 60);
    step("cancel", 0, 0, 0, 2'd0, 1);
    idle("gap", 1);

    // Inactivity timeout, then coin during VEND.
    do_reset();
    step("c10", 0, 1, 0, 2'd0, 0);
    idle("wait", 7);
    chk("tmo.early", 32'(a_change_valid), 0);
    idle("tmo", 1);
    chk("tmo.valid", 32'(a_change_valid), 1);
    chk("tmo.amt", 32'(a_change_amt), 10);
    idle("gap", 1);
    step("c5", 1, 0, 0, 2'd0, 0);
    step("sel0", 0, 0, 1, 2'd0, 0);
    step("coin_in_vend", 0, 1, 0, 2'd0, 0);
    chk("vend.coin_rej", 32'(a_coin_reject), 1);
    idle("gap", 2);

    // Out-of-range select on the 3-product machine, then async reset mid-VEND.
    do_reset();
    for (int k = 0; k < 3; k++) step("c15", 1, 1, 0, 2'd0, 0);
    step("c5", 1, 0, 0, 2'd0, 0);
    step("sel3", 0, 0, 1, 2'd3, 0);
    chk("oor.denied", 32'(b_sel_denied), 1);
    chk("oor.credit", 32'(b_credit), 50);
    chk("oor.a_vend", 32'(a_vend_valid), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async.vend0", 32'(a_vend_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      step("rnd", ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
